// File: rtl/obi_wb_pkg.sv
// Shared types for the OBI-to-Wishbone bridge: FSM state encoding and the
// default watchdog limit used when OBI_WB_TIMEOUT_EN is defined.
package obi_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/obi_wb_rr_arbiter.sv
// Combinational round-robin selector. The search starts at the port after
// i_rr_ptr, moves upward and wraps modulo NUM_PORTS. The first requester
// found wins and is reported as a one-hot grant and as a binary index.
module obi_wb_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_rr_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Scan ports starting after the pointer; the first requester wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      w_cand = IDX_W'((int'(i_rr_ptr) + i) % NUM_PORTS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_wb_bridge.sv
// Bridge from NUM_PORTS OBI master ports onto one Wishbone classic master.
// One transaction is in flight at a time. Arbitration is round-robin, and
// the response is returned on the owning port one cycle after ack/err.
// Optional bus watchdog: define OBI_WB_TIMEOUT_EN. It ends a stalled BUS
// phase with an error after TIMEOUT_CYCLES cycles.
//
// Handshake: a port's request is accepted in the cycle where obi_req_i and
// obi_gnt_o are both high. The payload is sampled in that same cycle. The
// response is a single-cycle obi_rvalid_o pulse on the owning port.
// obi_rdata_o and obi_err_o are meaningful only during that pulse.
module obi_wb_bridge
  import obi_wb_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  obi_req_i,
  output logic [NUM_PORTS-1:0]                  obi_gnt_o,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  obi_addr_i,
  input  logic [NUM_PORTS-1:0]                  obi_we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  obi_wdata_i,
  output logic [NUM_PORTS-1:0]                  obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 obi_rdata_o,
  output logic                                  obi_err_o,
  output logic                                  wb_cyc_o,
  output logic                                  wb_stb_o,
  output logic                                  wb_we_o,
  output logic [DATA_WIDTH/8-1:0]               wb_sel_o,
  output logic [ADDR_WIDTH-1:0]                 wb_addr_o,
  output logic [DATA_WIDTH-1:0]                 wb_data_o,
  input  logic [DATA_WIDTH-1:0]                 wb_data_i,
  input  logic                                  wb_ack_i,
  input  logic                                  wb_err_i,
  output logic [1:0]                            dbg_state_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_PORTS - 1);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_owner;
  logic                   r_we;
  logic [SEL_W-1:0]       r_sel;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic                   r_err;
  logic [NUM_PORTS-1:0]   r_rvalid;

  logic [NUM_PORTS-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]       w_arb_idx;
  logic                   w_arb_valid;
  logic                   w_can_grant;
  logic [NUM_PORTS-1:0]   w_owner_oh;
  logic                   w_timeout;

  obi_wb_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .i_req    (obi_req_i),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_arb_gnt),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  // Grants are only offered while no transaction occupies the bus, and never in reset
  assign w_can_grant = rst_n && ((r_state == IDLE) || (r_state == RESP));
  assign obi_gnt_o   = w_can_grant ? w_arb_gnt : '0;

  // One-hot decode of the current owner, used to route the response
  always_comb begin
    w_owner_oh = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_owner_oh[p] = (r_owner == IDX_W'(p));
    end
  end

`ifdef OBI_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Count BUS cycles. The count is zero in the first BUS cycle and held at zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state != BUS) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  // Expire in the BUS cycle whose count increment would reach TIMEOUT_CYCLES
  assign w_timeout = (r_state == BUS) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 1);
  assign w_timeout    = 1'b0;
`endif

  // Main FSM. It latches the request on grant, holds the bus, and captures the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= RR_RESET;
      r_owner  <= '0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= '0;
      case (r_state)
        IDLE, RESP: begin
          if (w_arb_valid) begin
            r_owner  <= w_arb_idx;
            r_rr_ptr <= w_arb_idx;
            r_we     <= obi_we_i[w_arb_idx];
            r_sel    <= obi_be_i[w_arb_idx];
            r_addr   <= obi_addr_i[w_arb_idx];
            r_wdata  <= obi_wdata_i[w_arb_idx];
            r_state  <= BUS;
          end else begin
            r_state  <= IDLE;
          end
        end
        BUS: begin
          if (wb_err_i) begin
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= w_owner_oh;
            r_state  <= RESP;
          end else if (wb_ack_i) begin
            r_err    <= 1'b0;
            r_rdata  <= r_we ? '0 : wb_data_i;
            r_rvalid <= w_owner_oh;
            r_state  <= RESP;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= w_owner_oh;
            r_state  <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign obi_rvalid_o = r_rvalid;
  assign obi_rdata_o  = r_rdata;
  assign obi_err_o    = r_err;
  assign wb_cyc_o     = (r_state == BUS);
  assign wb_stb_o     = (r_state == BUS);
  assign wb_we_o      = r_we;
  assign wb_sel_o     = r_sel;
  assign wb_addr_o    = r_addr;
  assign wb_data_o    = r_wdata;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Testbench for obi_wb_bridge with two ports and 32-bit address and data.
// With OBI_WB_TIMEOUT_EN defined, the no-ack sequence expects the watchdog
// to fire after 8 BUS cycles. Otherwise it expects the bus to stay held.
module tb_obi_wb_bridge;

  logic             clk;
  logic             rst_n;
  logic [1:0]       obi_req_i;
  logic [1:0]       obi_gnt_o;
  logic [1:0][31:0] obi_addr_i;
  logic [1:0]       obi_we_i;
  logic [1:0][3:0]  obi_be_i;
  logic [1:0][31:0] obi_wdata_i;
  logic [1:0]       obi_rvalid_o;
  logic [31:0]      obi_rdata_o;
  logic             obi_err_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic             wb_we_o;
  logic [3:0]       wb_sel_o;
  logic [31:0]      wb_addr_o;
  logic [31:0]      wb_data_o;
  logic [31:0]      wb_data_i;
  logic             wb_ack_i;
  logic             wb_err_i;
  logic [1:0]       dbg_state_o;

  int n_checks;
  int n_errors;
  logic [32:0] exp_q[$];

  obi_wb_bridge #(
    .NUM_PORTS      (2),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_sel_o     (wb_sel_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_data_i    (wb_data_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        ack;
    logic        err;
    logic [31:0] wbd;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rvalid;
    logic        e_cyc;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_zero();
    obi_req_i   = '0;
    obi_we_i    = '0;
    obi_addr_i  = '0;
    obi_be_i    = '0;
    obi_wdata_i = '0;
    wb_data_i   = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gnt"},    32'(obi_gnt_o),    32'h0);
    chk({tag, " rvalid"}, 32'(obi_rvalid_o), 32'h0);
    chk({tag, " rdata"},  obi_rdata_o,       32'h0);
    chk({tag, " err"},    32'(obi_err_o),    32'h0);
    chk({tag, " cyc"},    32'(wb_cyc_o),     32'h0);
    chk({tag, " stb"},    32'(wb_stb_o),     32'h0);
    chk({tag, " we"},     32'(wb_we_o),      32'h0);
    chk({tag, " sel"},    32'(wb_sel_o),     32'h0);
    chk({tag, " addr"},   wb_addr_o,         32'h0);
    chk({tag, " wdata"},  wb_data_o,         32'h0);
  endtask

  // Scoreboard: every rvalid pulse must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n && (obi_rvalid_o != 2'b00)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb unexpected rvalid: got %b err %b rdata %h expected none",
                 obi_rvalid_o, obi_err_o, obi_rdata_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({obi_err_o, obi_rdata_o} !== e) begin
          n_errors++;
          $display("FAIL sb response: got err %b rdata %h expected err %b rdata %h",
                   obi_err_o, obi_rdata_o, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    //        req    we     addr0         addr1         be0   be1   wd0           wd1           ack   err   wbd           e_gnt  e_rv   cyc   we    sel   e_addr        e_wdata       e_rdata       e_err
    vt[0]  = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[1]  = '{2'b01, 2'b00, 32'h1000,     32'h0,        4'hF, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b01, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[2]  = '{2'b00, 2'b00, 32'h1000,     32'h0,        4'hF, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 2'b00, 2'b00, 1'b1, 1'b0, 4'hF, 32'h1000,     32'h0,        32'h0,        1'b0};
    vt[3]  = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 2'b01, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'hDEADBEEF, 1'b0};
    vt[4]  = '{2'b10, 2'b10, 32'h0,        32'h2004,     4'h0, 4'h3, 32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0,        2'b10, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[5]  = '{2'b00, 2'b10, 32'h0,        32'h2004,     4'h0, 4'h3, 32'h0,        32'h12345678, 1'b0, 1'b0, 32'hAAAA5555, 2'b00, 2'b00, 1'b1, 1'b1, 4'h3, 32'h2004,     32'h12345678, 32'h0,        1'b0};
    vt[6]  = '{2'b00, 2'b10, 32'h0,        32'h2004,     4'h0, 4'h3, 32'h0,        32'h12345678, 1'b1, 1'b0, 32'hFFFFFFFF, 2'b00, 2'b00, 1'b1, 1'b1, 4'h3, 32'h2004,     32'h12345678, 32'h0,        1'b0};
    vt[7]  = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 2'b10, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[8]  = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h00001234, 2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[9]  = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[10] = '{2'b11, 2'b00, 32'h3000,     32'h4000,     4'hF, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b01, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[11] = '{2'b11, 2'b00, 32'h3000,     32'h4000,     4'hF, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 32'h11111111, 2'b00, 2'b00, 1'b1, 1'b0, 4'hF, 32'h3000,     32'h0,        32'h0,        1'b0};
    vt[12] = '{2'b11, 2'b00, 32'h3000,     32'h4000,     4'hF, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b10, 2'b01, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h11111111, 1'b0};
    vt[13] = '{2'b11, 2'b00, 32'h3000,     32'h4000,     4'hF, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 32'h22222222, 2'b00, 2'b00, 1'b1, 1'b0, 4'hF, 32'h4000,     32'h0,        32'h0,        1'b0};
    vt[14] = '{2'b11, 2'b00, 32'h3000,     32'h4000,     4'hF, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b01, 2'b10, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h22222222, 1'b0};
    vt[15] = '{2'b00, 2'b00, 32'h3000,     32'h4000,     4'hF, 4'hF, 32'h0,        32'h0,        1'b1, 1'b0, 32'h33333333, 2'b00, 2'b00, 1'b1, 1'b0, 4'hF, 32'h3000,     32'h0,        32'h0,        1'b0};
    vt[16] = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 2'b01, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h33333333, 1'b0};
    vt[17] = '{2'b01, 2'b01, 32'h5000,     32'h0,        4'hF, 4'h0, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 32'h0,        2'b01, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[18] = '{2'b00, 2'b01, 32'h5000,     32'h0,        4'hF, 4'h0, 32'hCAFEF00D, 32'h0,        1'b1, 1'b1, 32'hBADBADBA, 2'b00, 2'b00, 1'b1, 1'b1, 4'hF, 32'h5000,     32'hCAFEF00D, 32'h0,        1'b0};
    vt[19] = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 2'b01, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b1};
    vt[20] = '{2'b10, 2'b00, 32'h0,        32'h6000,     4'h0, 4'hF, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b10, 2'b00, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b0};
    vt[21] = '{2'b00, 2'b00, 32'h0,        32'h6000,     4'h0, 4'hF, 32'h0,        32'h0,        1'b0, 1'b1, 32'hFFFF0000, 2'b00, 2'b00, 1'b1, 1'b0, 4'hF, 32'h6000,     32'h0,        32'h0,        1'b0};
    vt[22] = '{2'b00, 2'b00, 32'h0,        32'h0,        4'h0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        2'b00, 2'b10, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        32'h0,        1'b1};

    // Reset: outputs must be zero even while both ports request
    rst_n = 1'b0;
    drive_zero();
    obi_req_i = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    drive_zero();
    rst_n = 1'b1;

    // Table-driven cycle vectors
    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      obi_req_i      = vt[k].req;
      obi_we_i       = vt[k].we;
      obi_addr_i[0]  = vt[k].addr0;
      obi_addr_i[1]  = vt[k].addr1;
      obi_be_i[0]    = vt[k].be0;
      obi_be_i[1]    = vt[k].be1;
      obi_wdata_i[0] = vt[k].wd0;
      obi_wdata_i[1] = vt[k].wd1;
      wb_ack_i       = vt[k].ack;
      wb_err_i       = vt[k].err;
      wb_data_i      = vt[k].wbd;
      if (vt[k].e_rvalid != 2'b00) exp_q.push_back({vt[k].e_err, vt[k].e_rdata});
      #2;
      chk($sformatf("r%0d gnt", k),    32'(obi_gnt_o),    32'(vt[k].e_gnt));
      chk($sformatf("r%0d rvalid", k), 32'(obi_rvalid_o), 32'(vt[k].e_rvalid));
      chk($sformatf("r%0d cyc", k),    32'(wb_cyc_o),     32'(vt[k].e_cyc));
      chk($sformatf("r%0d stb", k),    32'(wb_stb_o),     32'(vt[k].e_cyc));
      if (vt[k].e_cyc) begin
        chk($sformatf("r%0d we", k),    32'(wb_we_o),  32'(vt[k].e_we));
        chk($sformatf("r%0d sel", k),   32'(wb_sel_o), 32'(vt[k].e_sel));
        chk($sformatf("r%0d addr", k),  wb_addr_o,     vt[k].e_addr);
        chk($sformatf("r%0d wdata", k), wb_data_o,     vt[k].e_wdata);
      end
      if (vt[k].e_rvalid != 2'b00) begin
        chk($sformatf("r%0d rdata", k), obi_rdata_o,     vt[k].e_rdata);
        chk($sformatf("r%0d err", k),   32'(obi_err_o),  32'(vt[k].e_err));
      end
    end

    // Silent slave: the watchdog ends the cycle, or the bus is held until an ack
    @(posedge clk);
    #1;
    drive_zero();
    obi_req_i     = 2'b01;
    obi_addr_i[0] = 32'h7000;
    obi_be_i[0]   = 4'hF;
    #2;
    chk("wd gnt", 32'(obi_gnt_o), 32'h1);
`ifdef OBI_WB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      drive_zero();
      #2;
      chk($sformatf("wd c%0d cyc", c),    32'(wb_cyc_o),     32'h1);
      chk($sformatf("wd c%0d rvalid", c), 32'(obi_rvalid_o), 32'h0);
    end
    @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 32'h0});
    #2;
    chk("wd expire cyc",    32'(wb_cyc_o),     32'h0);
    chk("wd expire rvalid", 32'(obi_rvalid_o), 32'h1);
    chk("wd expire err",    32'(obi_err_o),    32'h1);
    chk("wd expire rdata",  obi_rdata_o,       32'h0);
`else
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      drive_zero();
      #2;
      chk($sformatf("hold c%0d cyc", c),    32'(wb_cyc_o),     32'h1);
      chk($sformatf("hold c%0d rvalid", c), 32'(obi_rvalid_o), 32'h0);
    end
    @(posedge clk);
    #1;
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h55AA55AA;
    #2;
    chk("hold ack cyc", 32'(wb_cyc_o), 32'h1);
    @(posedge clk);
    #1;
    drive_zero();
    exp_q.push_back({1'b0, 32'h55AA55AA});
    #2;
    chk("hold resp rvalid", 32'(obi_rvalid_o), 32'h1);
    chk("hold resp err",    32'(obi_err_o),    32'h0);
    chk("hold resp rdata",  obi_rdata_o,       32'h55AA55AA);
`endif

    // Reset in the middle of a BUS cycle
    @(posedge clk);
    #1;
    drive_zero();
    obi_req_i      = 2'b01;
    obi_we_i       = 2'b01;
    obi_addr_i[0]  = 32'h8000;
    obi_be_i[0]    = 4'hF;
    obi_wdata_i[0] = 32'hA5A5A5A5;
    #2;
    chk("mr gnt", 32'(obi_gnt_o), 32'h1);
    @(posedge clk);
    #1;
    drive_zero();
    #2;
    chk("mr bus cyc",  32'(wb_cyc_o), 32'h1);
    chk("mr bus addr", wb_addr_o,     32'h8000);
    #1;
    obi_req_i = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk_all_zero("mr in reset");
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    obi_req_i      = 2'b11;
    obi_addr_i[0]  = 32'h9000;
    obi_addr_i[1]  = 32'hA000;
    obi_be_i[0]    = 4'hF;
    obi_be_i[1]    = 4'hF;
    #2;
    chk("mr post gnt",    32'(obi_gnt_o),    32'h1);
    chk("mr post rvalid", 32'(obi_rvalid_o), 32'h0);
    @(posedge clk);
    #1;
    drive_zero();
    wb_ack_i  = 1'b1;
    wb_data_i = 32'h0BADC0DE;
    #2;
    chk("mr post cyc",  32'(wb_cyc_o), 32'h1);
    chk("mr post addr", wb_addr_o,     32'h9000);
    @(posedge clk);
    #1;
    drive_zero();
    exp_q.push_back({1'b0, 32'h0BADC0DE});
    #2;
    chk("mr post rvalid1", 32'(obi_rvalid_o), 32'h1);
    chk("mr post rdata",   obi_rdata_o,       32'h0BADC0DE);
    @(posedge clk);
    #1;
    #2;
    chk("mr post idle rvalid", 32'(obi_rvalid_o), 32'h0);
    chk("mr post idle cyc",    32'(wb_cyc_o),     32'h0);

    @(posedge clk);
    #1;
    chk("sb queue empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
